uart_tx_fifo: RTL and testbench

Byte FIFO and transmit scheduler sitting directly upstream of the `uart` block's transmit path. Host logic pushes bytes at clock rate. The block buffers them and feeds them one at a time to the UART transmitter over the `din` / `write_en` / `tx_busy` handshake, so a burst of writes leaves the wire as back-to-back frames without host polling.

---
 rtl/uart_tx_fifo_if.sv | 26 ++
 rtl/uart_tx_fifo.sv | 106 ++++++++++
 tb/tb_uart_tx_fifo.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Host-write and UART-transmit handshake bundle for uart_tx_fifo.
interface uart_tx_fifo_if #(
  parameter int DEPTH_LOG2 = 4
) ();
  logic [7:0]          wr_data;
  logic                wr_en;
  logic                full;
  logic                empty;
  logic [DEPTH_LOG2:0] count;
  logic                overflow;
  logic                ovf_clr;
  logic                idle;
  logic [7:0]          uart_din;
  logic                uart_write_en;
  logic                uart_tx_busy;

  modport master (
    output wr_data, wr_en, ovf_clr, uart_tx_busy,
    input  full, empty, count, overflow, idle, uart_din, uart_write_en
  );

  modport slave (
    input  wr_data, wr_en, ovf_clr, uart_tx_busy,
    output full, empty, count, overflow, idle, uart_din, uart_write_en
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus IDLE/LOAD/WAIT scheduler that feeds queued bytes to the UART
// transmitter one frame at a time over the din/write_en/tx_busy handshake.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input logic           clk50,
  input logic           rst_n,
  uart_tx_fifo_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;

  state_t                state_reg, state_next;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [DEPTH_LOG2:0]   count_reg, count_next;
  logic                  full_reg, empty_reg;
  logic                  overflow_reg;
  logic [7:0]            din_reg;
  logic                  write_en_reg;
  logic                  busy_meta_reg, busy_s_reg;
  logic                  push, pop;

  // full_reg reflects occupancy at the start of the cycle, so a write on a
  // full FIFO is dropped even if a pop frees a slot on the same edge.
  assign push = bus.wr_en && !full_reg;

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if ((count_reg != '0) && !busy_s_reg) begin
          pop        = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (busy_s_reg) state_next = WAIT;
      end
      WAIT: begin
        if (!busy_s_reg) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + 1'b1;
    end else if (pop && !push) begin
      count_next = count_reg - 1'b1;
    end
  end

  // Storage array carries no reset so it can map onto distributed RAM.
  always_ff @(posedge clk50) begin
    if (push) mem[wr_ptr_reg] <= bus.wr_data;
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      full_reg      <= 1'b0;
      empty_reg     <= 1'b1;
      overflow_reg  <= 1'b0;
      din_reg       <= 8'h00;
      write_en_reg  <= 1'b0;
      busy_meta_reg <= 1'b0;
      busy_s_reg    <= 1'b0;
    end else begin
      busy_meta_reg <= bus.uart_tx_busy;
      busy_s_reg    <= busy_meta_reg;
      state_reg     <= state_next;
      write_en_reg  <= (state_next == LOAD);
      count_reg     <= count_next;
      full_reg      <= (count_next == FULL_COUNT);
      empty_reg     <= (count_next == '0);
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop) begin
        din_reg    <= mem[rd_ptr_reg];
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      // A dropped write takes priority over a clear in the same cycle.
      if (bus.wr_en && full_reg) begin
        overflow_reg <= 1'b1;
      end else if (bus.ovf_clr) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  assign bus.full          = full_reg;
  assign bus.empty         = empty_reg;
  assign bus.count         = count_reg;
  assign bus.overflow      = overflow_reg;
  assign bus.idle          = empty_reg && (state_reg == IDLE);
  assign bus.uart_din      = din_reg;
  assign bus.uart_write_en = write_en_reg;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo with a behavioural UART busy model.
module tb_uart_tx_fifo;
  logic clk50;
  logic rst_n;

  uart_tx_fifo_if #(.DEPTH_LOG2(4)) ifc ();

  uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
    .clk50(clk50),
    .rst_n(rst_n),
    .bus  (ifc.slave)
  );

  int         checks = 0;
  int         errors = 0;
  bit         model_en = 1'b0;
  int         model_len = 20;
  logic [7:0] seen [$];
  logic       we_prev = 1'b0;

  initial begin
    clk50 = 1'b0;
    forever #5 clk50 = ~clk50;
  end

  // Record the byte presented on every rising uart_write_en.
  initial begin
    forever begin
      @(posedge clk50);
      #1;
      if (ifc.uart_write_en === 1'b1 && we_prev !== 1'b1) seen.push_back(ifc.uart_din);
      we_prev = ifc.uart_write_en;
    end
  end

  // UART transmitter model: busy rises 3 cycles after a request, lasts model_len cycles.
  initial begin
    logic [7:0] d;
    forever begin
      @(negedge clk50);
      if (model_en && ifc.uart_write_en === 1'b1 && ifc.uart_tx_busy === 1'b0) begin
        d = ifc.uart_din;
        repeat (3) @(negedge clk50);
        ifc.uart_tx_busy = 1'b1;
        repeat (model_len) @(negedge clk50);
        checks++;
        if (ifc.uart_din !== d) begin
          errors++;
          $display("FAIL din_stable: uart_din=%02h expected %02h", ifc.uart_din, d);
        end
        ifc.uart_tx_busy = 1'b0;
      end
    end
  end

  task automatic wait_drain(input int n, input int cap, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < cap; i++) begin
      @(negedge clk50);
      if (seen.size() >= n && ifc.idle === 1'b1 && ifc.uart_tx_busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    ifc.wr_en = 1'b0; ifc.wr_data = 8'h00; ifc.ovf_clr = 1'b0; ifc.uart_tx_busy = 1'b0;
    model_en = 1'b0;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk50);
    rst_n = 1'b1;
    @(negedge clk50);
    checks++; if (ifc.count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", ifc.count); end
    checks++; if (ifc.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", ifc.empty); end
    checks++; if (ifc.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", ifc.full); end
    checks++; if (ifc.idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b expected 1", ifc.idle); end
    checks++; if (ifc.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", ifc.overflow); end
    checks++; if (ifc.uart_write_en !== 1'b0) begin errors++; $display("FAIL reset_write_en: got %b expected 0", ifc.uart_write_en); end
    checks++; if (ifc.uart_din !== 8'h00) begin errors++; $display("FAIL reset_din: got %02h expected 00", ifc.uart_din); end
    // Get into LOAD, then reset without a clock edge.
    ifc.wr_data = 8'h3C; ifc.wr_en = 1'b1;
    @(negedge clk50);
    ifc.wr_en = 1'b0;
    @(negedge clk50);
    checks++; if (ifc.uart_write_en !== 1'b1) begin errors++; $display("FAIL midload_we: got %b expected 1", ifc.uart_write_en); end
    checks++; if (ifc.uart_din !== 8'h3C) begin errors++; $display("FAIL midload_din: got %02h expected 3c", ifc.uart_din); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ifc.uart_write_en !== 1'b0) begin errors++; $display("FAIL async_we: got %b expected 0", ifc.uart_write_en); end
    checks++; if (ifc.uart_din !== 8'h00) begin errors++; $display("FAIL async_din: got %02h expected 00", ifc.uart_din); end
    checks++; if (ifc.idle !== 1'b1) begin errors++; $display("FAIL async_idle: got %b expected 1", ifc.idle); end
    @(negedge clk50);
    rst_n = 1'b1;
    @(negedge clk50);
    checks++; if (ifc.count !== 5'd0) begin errors++; $display("FAIL post_reset_count: got %0d expected 0", ifc.count); end
    checks++; if (ifc.empty !== 1'b1) begin errors++; $display("FAIL post_reset_empty: got %b expected 1", ifc.empty); end
    checks++; if (ifc.uart_write_en !== 1'b0) begin errors++; $display("FAIL post_reset_we: got %b expected 0", ifc.uart_write_en); end
    $display("test_reset done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_single();
    seen.delete();
    ifc.wr_data = 8'hA5; ifc.wr_en = 1'b1;
    @(negedge clk50);
    ifc.wr_en = 1'b0;
    checks++; if (ifc.count !== 5'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", ifc.count); end
    checks++; if (ifc.uart_write_en !== 1'b0) begin errors++; $display("FAIL single_we_early: got %b expected 0", ifc.uart_write_en); end
    @(negedge clk50);
    checks++; if (ifc.uart_write_en !== 1'b1) begin errors++; $display("FAIL single_we: got %b expected 1", ifc.uart_write_en); end
    checks++; if (ifc.uart_din !== 8'hA5) begin errors++; $display("FAIL single_din: got %02h expected a5", ifc.uart_din); end
    checks++; if (ifc.count !== 5'd0) begin errors++; $display("FAIL single_count_pop: got %0d expected 0", ifc.count); end
    repeat (3) @(negedge clk50);
    ifc.uart_tx_busy = 1'b1;
    @(negedge clk50);
    checks++; if (ifc.uart_write_en !== 1'b1) begin errors++; $display("FAIL busy_t0_we: got %b expected 1", ifc.uart_write_en); end
    @(negedge clk50);
    checks++; if (ifc.uart_write_en !== 1'b1) begin errors++; $display("FAIL busy_t1_we: got %b expected 1", ifc.uart_write_en); end
    @(negedge clk50);
    checks++; if (ifc.uart_write_en !== 1'b0) begin errors++; $display("FAIL busy_t2_we: got %b expected 0", ifc.uart_write_en); end
    repeat (97) @(negedge clk50);
    ifc.uart_tx_busy = 1'b0;
    repeat (2) @(negedge clk50);
    checks++; if (ifc.idle !== 1'b0) begin errors++; $display("FAIL single_idle_wait: got %b expected 0", ifc.idle); end
    @(negedge clk50);
    checks++; if (ifc.idle !== 1'b1) begin errors++; $display("FAIL single_idle: got %b expected 1", ifc.idle); end
    checks++; if (seen.size() !== 1) begin errors++; $display("FAIL single_pulses: got %0d expected 1", seen.size()); end
    else begin
      checks++; if (seen[0] !== 8'hA5) begin errors++; $display("FAIL single_seen: got %02h expected a5", seen[0]); end
    end
    $display("test_single done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_burst();
    bit ok;
    seen.delete();
    model_len = 20;
    model_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ifc.wr_data = 8'(i); ifc.wr_en = 1'b1;
      @(negedge clk50);
    end
    ifc.wr_en = 1'b0;
    // One byte has already been popped into the transmitter.
    checks++; if (ifc.count !== 5'd15) begin errors++; $display("FAIL burst_count: got %0d expected 15", ifc.count); end
    checks++; if (ifc.full !== 1'b0) begin errors++; $display("FAIL burst_full: got %b expected 0", ifc.full); end
    wait_drain(16, 2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL burst_drain: timeout with %0d of 16 bytes", seen.size()); end
    checks++; if (seen.size() !== 16) begin errors++; $display("FAIL burst_size: got %0d expected 16", seen.size()); end
    else begin
      for (int i = 0; i < 16; i++) begin
        checks++; if (seen[i] !== 8'(i)) begin errors++; $display("FAIL burst_order[%0d]: got %02h expected %02h", i, seen[i], 8'(i)); end
      end
    end
    model_en = 1'b0;
    $display("test_burst done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_overflow();
    bit ok;
    seen.delete();
    ifc.uart_tx_busy = 1'b1;
    repeat (3) @(negedge clk50);
    for (int i = 0; i < 17; i++) begin
      ifc.wr_data = 8'(8'h20 + i); ifc.wr_en = 1'b1;
      @(negedge clk50);
      if (i == 15) begin
        checks++; if (ifc.full !== 1'b1) begin errors++; $display("FAIL ovf_full16: got %b expected 1", ifc.full); end
        checks++; if (ifc.overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0", ifc.overflow); end
      end
    end
    ifc.wr_en = 1'b0;
    checks++; if (ifc.count !== 5'd16) begin errors++; $display("FAIL ovf_count: got %0d expected 16", ifc.count); end
    checks++; if (ifc.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", ifc.overflow); end
    ifc.ovf_clr = 1'b1;
    @(negedge clk50);
    ifc.ovf_clr = 1'b0;
    checks++; if (ifc.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", ifc.overflow); end
    ifc.wr_data = 8'h77; ifc.wr_en = 1'b1; ifc.ovf_clr = 1'b1;
    @(negedge clk50);
    ifc.wr_en = 1'b0; ifc.ovf_clr = 1'b0;
    checks++; if (ifc.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %b expected 1", ifc.overflow); end
    checks++; if (ifc.count !== 5'd16) begin errors++; $display("FAIL ovf_count2: got %0d expected 16", ifc.count); end
    ifc.ovf_clr = 1'b1;
    @(negedge clk50);
    ifc.ovf_clr = 1'b0;
    ifc.uart_tx_busy = 1'b0;
    model_len = 4;
    model_en = 1'b1;
    wait_drain(16, 2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_drain: timeout with %0d of 16 bytes", seen.size()); end
    checks++; if (seen.size() !== 16) begin errors++; $display("FAIL ovf_size: got %0d expected 16", seen.size()); end
    else begin
      for (int i = 0; i < 16; i++) begin
        checks++; if (seen[i] !== 8'(8'h20 + i)) begin errors++; $display("FAIL ovf_order[%0d]: got %02h expected %02h", i, seen[i], 8'(8'h20 + i)); end
      end
    end
    model_en = 1'b0;
    $display("test_overflow done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_wrap();
    logic [7:0] exp_q [$];
    int sent = 0;
    int max_cnt = 0;
    bit ok;
    seen.delete();
    model_len = 2;
    model_en = 1'b1;
    for (int cyc = 0; cyc < 5000 && sent < 40; cyc++) begin
      if (ifc.full === 1'b0 && $urandom_range(1, 0) == 1) begin
        ifc.wr_data = 8'(sent * 37 + 11); ifc.wr_en = 1'b1;
        exp_q.push_back(8'(sent * 37 + 11));
        sent++;
      end else begin
        ifc.wr_en = 1'b0;
      end
      @(negedge clk50);
      if (int'(ifc.count) > max_cnt) max_cnt = int'(ifc.count);
    end
    ifc.wr_en = 1'b0;
    checks++; if (sent !== 40) begin errors++; $display("FAIL wrap_sent: got %0d expected 40", sent); end
    wait_drain(40, 4000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_drain: timeout with %0d of 40 bytes", seen.size()); end
    checks++; if (max_cnt > 16) begin errors++; $display("FAIL wrap_max_count: got %0d expected <=16", max_cnt); end
    checks++; if (ifc.count !== 5'd0) begin errors++; $display("FAIL wrap_count_end: got %0d expected 0", ifc.count); end
    checks++; if (seen.size() !== 40) begin errors++; $display("FAIL wrap_size: got %0d expected 40", seen.size()); end
    else begin
      for (int i = 0; i < 40; i++) begin
        checks++; if (seen[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_order[%0d]: got %02h expected %02h", i, seen[i], exp_q[i]); end
      end
    end
    model_en = 1'b0;
    $display("test_wrap done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_simul();
    bit ok;
    seen.delete();
    ifc.uart_tx_busy = 1'b1;
    repeat (3) @(negedge clk50);
    for (int i = 0; i < 3; i++) begin
      ifc.wr_data = 8'(8'h50 + i); ifc.wr_en = 1'b1;
      @(negedge clk50);
    end
    ifc.wr_en = 1'b0;
    checks++; if (ifc.count !== 5'd3) begin errors++; $display("FAIL simul_count3: got %0d expected 3", ifc.count); end
    ifc.uart_tx_busy = 1'b0;
    repeat (2) @(negedge clk50);
    checks++; if (ifc.uart_write_en !== 1'b0) begin errors++; $display("FAIL simul_we_pre: got %b expected 0", ifc.uart_write_en); end
    // The next edge is the IDLE->LOAD pop; push on the same edge.
    ifc.wr_data = 8'h53; ifc.wr_en = 1'b1;
    @(negedge clk50);
    ifc.wr_en = 1'b0;
    checks++; if (ifc.count !== 5'd3) begin errors++; $display("FAIL simul_count: got %0d expected 3", ifc.count); end
    checks++; if (ifc.uart_write_en !== 1'b1) begin errors++; $display("FAIL simul_we: got %b expected 1", ifc.uart_write_en); end
    checks++; if (ifc.uart_din !== 8'h50) begin errors++; $display("FAIL simul_din: got %02h expected 50", ifc.uart_din); end
    model_len = 4;
    model_en = 1'b1;
    wait_drain(4, 1000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL simul_drain: timeout with %0d of 4 bytes", seen.size()); end
    checks++; if (seen.size() !== 4) begin errors++; $display("FAIL simul_size: got %0d expected 4", seen.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (seen[i] !== 8'(8'h50 + i)) begin errors++; $display("FAIL simul_order[%0d]: got %02h expected %02h", i, seen[i], 8'(8'h50 + i)); end
      end
    end
    model_en = 1'b0;
    $display("test_simul done: checks=%0d errors=%0d", checks, errors);
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_wrap();
    test_simul();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
